inst_fetch: RTL and testbench

Instruction fetch unit for the 8-bit lab processor, sitting between the instruction memory and the decode stage. It owns the program counter and drives `ReadAddress` into the instruction memory, whose `instruction` output is combinational. It latches each word into a one-entry instruction register with a valid/ready handshake toward decode, and folds unconditional jumps locally. It also accepts redirects from execute and halts when the PC runs past the end of the program.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/inst_fetch_if.sv | 29 ++
 rtl/pc_next.sv | 32 +++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit lab processor: opcodes, field positions,
// default widths and the fetch-unit state and next-PC select encodings.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_INST_W = 8;

  localparam int unsigned OP_HI = 7;
  localparam int unsigned OP_LO = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchRun,
    FetchHalt
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold,
    PcInc,
    PcJump,
    PcRedirect
  } pc_sel_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-memory port, decode handshake, redirect and status.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 8
);

  logic              start;
  logic [ADDR_W-1:0] ReadAddress;
  logic [INST_W-1:0] instruction;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              inst_valid;
  logic              inst_ready;
  logic              flush;
  logic [ADDR_W-1:0] redirect_addr;
  logic              done;
  logic [7:0]        fetch_count;

  modport master (
    input  start, instruction, inst_ready, flush, redirect_addr,
    output ReadAddress, inst_out, pc_out, inst_valid, done, fetch_count
  );

  modport slave (
    output start, instruction, inst_ready, flush, redirect_addr,
    input  ReadAddress, inst_out, pc_out, inst_valid, done, fetch_count
  );

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: hold, increment, folded-jump target or redirect.
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        jump_off_i,
  input  logic [ADDR_W-1:0] redirect_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_sext;

  assign pc_inc   = pc_i + ADDR_W'(1);
  assign off_sext = {{(ADDR_W-2){jump_off_i[1]}}, jump_off_i};

  always_comb begin
    pc_o = pc_i;
    unique case (sel_i)
      PcHold:     pc_o = pc_i;
      PcInc:      pc_o = pc_inc;
      // Target is relative to the word after the jump; wraps modulo 2^ADDR_W.
      PcJump:     pc_o = pc_inc + off_sext;
      PcRedirect: pc_o = redirect_i;
      default:    pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fills a one-entry instruction register
// toward decode, folds unconditional jumps and halts at the end of the program.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned INST_W   = DEF_INST_W,
  parameter int unsigned PROG_LEN = 6
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] EndAddr = ADDR_W'(PROG_LEN);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [7:0]        count_q, count_d;

  pc_sel_e pc_sel;
  logic    slot_free;
  logic    consume;
  logic    capture;
  logic    flush_act;
  logic    at_end;
  logic    is_jump;

  assign slot_free = !valid_q || bus.inst_ready;
  assign consume   = valid_q && bus.inst_ready;
  assign flush_act = bus.flush && (state_q != FetchIdle);
  assign capture   = (state_q == FetchRun) && slot_free && !bus.flush;
  assign at_end    = (pc_q == EndAddr);
  assign is_jump   = (bus.instruction[OP_HI:OP_LO] == OP_J);

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .sel_i      (pc_sel),
    .pc_i       (pc_q),
    .jump_off_i (bus.instruction[1:0]),
    .redirect_i (bus.redirect_addr),
    .pc_o       (pc_d)
  );

  always_comb begin
    state_d  = state_q;
    pc_sel   = PcHold;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (flush_act) begin
      // Redirect beats both capture and HALT.
      pc_sel  = PcRedirect;
      valid_d = 1'b0;
      state_d = FetchRun;
    end else begin
      unique case (state_q)
        FetchIdle: begin
          if (bus.start) state_d = FetchRun;
        end
        FetchRun: begin
          if (capture) begin
            if (at_end) begin
              state_d = FetchHalt;
              if (consume) valid_d = 1'b0;
            end else if (is_jump) begin
              pc_sel = PcJump;
              if (consume) valid_d = 1'b0;
            end else begin
              pc_sel   = PcInc;
              inst_d   = bus.instruction;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            end
          end
        end
        FetchHalt: begin
          if (consume) valid_d = 1'b0;
        end
        default: state_d = FetchIdle;
      endcase
    end

    done_d = (state_d == FetchHalt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FetchIdle;
      pc_q     <= '0;
      inst_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign bus.ReadAddress = pc_q;
  assign bus.inst_out    = inst_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.inst_valid  = valid_q;
  assign bus.done        = done_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: three instances with program lengths 6, 3 and 255.
module tb_inst_fetch;

  logic clk;
  logic reset;

  int n_cmp;
  int n_bad;

  logic [7:0] rom_a [256];
  logic [7:0] rom_b [256];
  logic [7:0] rom_c [256];

  inst_fetch_if #(.ADDR_W(8), .INST_W(8)) bus_a ();
  inst_fetch_if #(.ADDR_W(8), .INST_W(8)) bus_b ();
  inst_fetch_if #(.ADDR_W(8), .INST_W(8)) bus_c ();

  assign bus_a.instruction = rom_a[bus_a.ReadAddress];
  assign bus_b.instruction = rom_b[bus_b.ReadAddress];
  assign bus_c.instruction = rom_c[bus_c.ReadAddress];

  inst_fetch #(.ADDR_W(8), .INST_W(8), .PROG_LEN(6)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  inst_fetch #(.ADDR_W(8), .INST_W(8), .PROG_LEN(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  inst_fetch #(.ADDR_W(8), .INST_W(8), .PROG_LEN(255)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [6];
    prog = '{8'h71, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2};
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 8'h00;
      rom_b[i] = 8'h00;
      rom_c[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) rom_a[i] = prog[i];
    rom_b[0] = 8'h00;
    rom_b[1] = 8'h41;
    rom_b[2] = 8'h82;

    bus_a.start = 1'b0; bus_a.inst_ready = 1'b1; bus_a.flush = 1'b0; bus_a.redirect_addr = '0;
    bus_b.start = 1'b0; bus_b.inst_ready = 1'b1; bus_b.flush = 1'b0; bus_b.redirect_addr = '0;
    bus_c.start = 1'b0; bus_c.inst_ready = 1'b1; bus_c.flush = 1'b0; bus_c.redirect_addr = '0;

    // Reset state
    reset = 1'b1;
    #1;
    chk("rst_addr", 32'(bus_a.ReadAddress), 0);
    chk("rst_inst", 32'(bus_a.inst_out), 0);
    chk("rst_pcout", 32'(bus_a.pc_out), 0);
    chk("rst_valid", 32'(bus_a.inst_valid), 0);
    chk("rst_done", 32'(bus_a.done), 0);
    chk("rst_count", 32'(bus_a.fetch_count), 0);
    tick();
    reset = 1'b0;

    // Production program with a folded backward jump
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("a_idle_valid", 32'(bus_a.inst_valid), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("a_inst", 32'(bus_a.inst_out), 32'(prog[i]));
      chk("a_pcout", 32'(bus_a.pc_out), i);
      chk("a_valid", 32'(bus_a.inst_valid), 1);
    end
    tick();
    chk("a_jump_bubble", 32'(bus_a.inst_valid), 0);
    chk("a_jump_target", 32'(bus_a.ReadAddress), 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("a_loop_inst", 32'(bus_a.inst_out), 32'h05);
      chk("a_loop_pcout", 32'(bus_a.pc_out), 4);
      chk("a_loop_valid", 32'(bus_a.inst_valid), 1);
      tick();
      chk("a_loop_bubble", 32'(bus_a.inst_valid), 0);
      chk("a_loop_done", 32'(bus_a.done), 0);
    end
    chk("a_loop_count", 32'(bus_a.fetch_count), 8);

    // Backpressure, then flush while holding and flush on a capture cycle
    do_reset();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick();
    bus_a.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_inst", 32'(bus_a.inst_out), 32'h71);
      chk("bp_addr", 32'(bus_a.ReadAddress), 1);
      chk("bp_count", 32'(bus_a.fetch_count), 1);
      chk("bp_valid", 32'(bus_a.inst_valid), 1);
    end
    bus_a.inst_ready = 1'b1;
    tick();
    chk("bp_resume_inst", 32'(bus_a.inst_out), 32'h4D);
    chk("bp_resume_pc", 32'(bus_a.pc_out), 1);
    bus_a.inst_ready = 1'b0;
    bus_a.flush = 1'b1;
    bus_a.redirect_addr = 8'd3;
    tick();
    chk("fl_valid", 32'(bus_a.inst_valid), 0);
    chk("fl_addr", 32'(bus_a.ReadAddress), 3);
    bus_a.flush = 1'b0;
    bus_a.inst_ready = 1'b1;
    tick();
    chk("fl_next_inst", 32'(bus_a.inst_out), 32'hB7);
    chk("fl_next_pc", 32'(bus_a.pc_out), 3);
    chk("fl_next_count", 32'(bus_a.fetch_count), 3);
    bus_a.flush = 1'b1;
    bus_a.redirect_addr = 8'd0;
    tick();
    chk("flcap_valid", 32'(bus_a.inst_valid), 0);
    chk("flcap_addr", 32'(bus_a.ReadAddress), 0);
    chk("flcap_count", 32'(bus_a.fetch_count), 3);
    bus_a.flush = 1'b0;
    tick();
    chk("flcap_inst", 32'(bus_a.inst_out), 32'h71);
    chk("flcap_count2", 32'(bus_a.fetch_count), 4);

    // Asynchronous reset mid-run clears outputs before the next edge
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_addr", 32'(bus_a.ReadAddress), 0);
    chk("arst_inst", 32'(bus_a.inst_out), 0);
    chk("arst_pcout", 32'(bus_a.pc_out), 0);
    chk("arst_valid", 32'(bus_a.inst_valid), 0);
    chk("arst_count", 32'(bus_a.fetch_count), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst_stays_idle", 32'(bus_a.inst_valid), 0);

    // Straight-line program halts; flush in IDLE ignored; flush out of HALT
    do_reset();
    bus_b.flush = 1'b1;
    bus_b.redirect_addr = 8'd2;
    tick();
    chk("b_idle_flush", 32'(bus_b.ReadAddress), 0);
    bus_b.flush = 1'b0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_inst", 32'(bus_b.inst_out), 32'(rom_b[i]));
      chk("b_pcout", 32'(bus_b.pc_out), i);
    end
    tick();
    chk("b_done", 32'(bus_b.done), 1);
    chk("b_valid", 32'(bus_b.inst_valid), 0);
    chk("b_count", 32'(bus_b.fetch_count), 3);
    chk("b_addr", 32'(bus_b.ReadAddress), 3);
    tick();
    chk("b_done_hold", 32'(bus_b.done), 1);
    bus_b.flush = 1'b1;
    bus_b.redirect_addr = 8'd1;
    tick();
    chk("b_unhalt_done", 32'(bus_b.done), 0);
    chk("b_unhalt_addr", 32'(bus_b.ReadAddress), 1);
    bus_b.flush = 1'b0;
    tick();
    chk("b_unhalt_inst", 32'(bus_b.inst_out), 32'h41);
    chk("b_unhalt_pc", 32'(bus_b.pc_out), 1);
    chk("b_unhalt_count", 32'(bus_b.fetch_count), 4);

    // Counter saturation over a 255-word program
    do_reset();
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    for (int i = 0; i < 300 && !bus_c.done; i++) tick();
    chk("c_done", 32'(bus_c.done), 1);
    chk("c_count", 32'(bus_c.fetch_count), 255);
    chk("c_pcout", 32'(bus_c.pc_out), 254);
    chk("c_addr", 32'(bus_c.ReadAddress), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
